// File: rtl/calc_pkg.sv
// Shared types for the calculator datapath.
// Holds the serial adder FSM encoding and sizing helpers.
package calc_pkg;

   localparam int CALC_WIDTH = 8;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DONE
   } serial_state_t;

   function automatic int cnt_width(input int width);
      return (width < 2) ? 1 : $clog2(width);
   endfunction

endpackage

// File: rtl/serial_adder_ctrl_fa.sv
// One-bit full adder built from two half adders.
// Shared by the bit-serial adder controller.
module half_adder (
   input  logic a_i,
   input  logic b_i,
   output logic s_o,
   output logic c_o
);
   assign s_o = a_i ^ b_i;
   assign c_o = a_i & b_i;
endmodule

module full_adder (
   input  logic a_i,
   input  logic b_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);
   logic s0;
   logic c0;
   logic c1;

   half_adder u_ha0 (
      .a_i (a_i),
      .b_i (b_i),
      .s_o (s0),
      .c_o (c0)
   );

   half_adder u_ha1 (
      .a_i (s0),
      .b_i (c_i),
      .s_o (s_o),
      .c_o (c1)
   );

   assign c_o = c0 | c1;
endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: one full-adder cell, LSB first,
// one bit per clock, bracketed by a start/busy/done handshake.
module serial_adder_ctrl
   import calc_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             cin_i,
   output logic             busy_o,
   output logic             done_o,
   output logic [WIDTH-1:0] sum_o,
   output logic             cout_o,
   output logic             ovf_o
);

   localparam int CW = cnt_width(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

   serial_state_t state, state_n;

   logic [CW-1:0]    cnt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] sum_sr;
   logic             carry;
   logic             cout_q;
   logic             ovf_q;
   logic             fa_s;
   logic             fa_c;
   logic             accept;
   logic             last;

   full_adder u_fa (
      .a_i (a_sr[0]),
      .b_i (b_sr[0]),
      .c_i (carry),
      .s_o (fa_s),
      .c_o (fa_c)
   );

   assign accept = start_i && (state != S_RUN);
   assign last   = (cnt == LAST);

   always_comb begin
      state_n = state;
      unique case (state)
         S_IDLE:  if (start_i) state_n = S_RUN;
         S_RUN:   if (last) state_n = S_DONE;
         S_DONE:  state_n = start_i ? S_RUN : S_IDLE;
         default: state_n = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state  <= S_IDLE;
         cnt    <= '0;
         a_sr   <= '0;
         b_sr   <= '0;
         sum_sr <= '0;
         carry  <= 1'b0;
         cout_q <= 1'b0;
         ovf_q  <= 1'b0;
      end else begin
         state <= state_n;
         if (accept) begin
            a_sr   <= a_i;
            b_sr   <= b_i;
            carry  <= cin_i;
            cnt    <= '0;
            sum_sr <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
         end else if (state == S_RUN) begin
            sum_sr <= {fa_s, sum_sr[WIDTH-1:1]};
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            carry  <= fa_c;
            cnt    <= cnt + CW'(1);
            // carry still holds the carry into the MSB here
            if (last) begin
               cout_q <= fa_c;
               ovf_q  <= carry ^ fa_c;
            end
         end
      end
   end

   assign busy_o = (state == S_RUN);
   assign done_o = (state == S_DONE);
   assign sum_o  = sum_sr;
   assign cout_o = cout_q;
   assign ovf_o  = ovf_q;

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl at WIDTH=8.
// Table vectors, directed corner sequences and a random model.
module tb_serial_adder_ctrl;

   localparam int W = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;

   int checks = 0;
   int failures = 0;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk_i   (clk),
      .rst_i   (rst),
      .start_i (start),
      .a_i     (a),
      .b_i     (b),
      .cin_i   (cin),
      .busy_o  (busy),
      .done_o  (done),
      .sum_o   (sum),
      .cout_o  (cout),
      .ovf_o   (ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [W-1:0] sum;
      logic         cout;
      logic         ovf;
   } vec_t;

   vec_t vecs[7];

   task automatic check(input string nm, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: plain integer addition and the sign rule for overflow.
   task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                        input logic mc, output logic [W-1:0] ms,
                        output logic mco, output logic mov);
      int unsigned t;
      int sa, sb, ss;
      t   = int'(ma) + int'(mb) + int'(mc);
      ms  = W'(t);
      mco = (t >= (1 << W));
      sa  = ma[W-1] ? int'(ma) - (1 << W) : int'(ma);
      sb  = mb[W-1] ? int'(mb) - (1 << W) : int'(mb);
      ss  = sa + sb + int'(mc);
      mov = (ss > (1 << (W - 1)) - 1) || (ss < -(1 << (W - 1)));
   endtask

   // Caller has start=1 and operands set at a negedge; returns at the
   // negedge of the done cycle with start=0 unless the caller re-arms.
   task automatic run_op(input string nm, input logic [W-1:0] es,
                         input logic ec, input logic ev, input bit noise);
      logic [31:0] bm;
      logic [31:0] dm;
      bm = '0;
      dm = '0;
      @(posedge clk);
      for (int k = 1; k <= W + 1; k++) begin
         @(negedge clk);
         bm[k] = busy;
         dm[k] = done;
         if (k == 1) begin
            check({nm, "_clr"}, {22'd0, sum, cout, ovf}, 32'd0);
            start = 1'b0;
            a = W'($urandom);
            b = W'($urandom);
            cin = 1'($urandom);
         end
         if (noise && k >= 2 && k <= 6) begin
            start = k[0];
            a = W'($urandom);
            b = W'($urandom);
         end else if (k > 1) begin
            start = 1'b0;
         end
      end
      check({nm, "_busy"}, bm, ((32'd1 << W) - 32'd1) << 1);
      check({nm, "_done"}, dm, 32'd1 << (W + 1));
      check({nm, "_res"}, {22'd0, sum, cout, ovf}, {22'd0, es, ec, ev});
   endtask

   task automatic idle_check(input string nm, input logic [W-1:0] es,
                             input logic ec, input logic ev);
      @(negedge clk);
      check({nm, "_idle"}, {20'd0, busy, done, sum, cout, ovf},
            {20'd0, 1'b0, 1'b0, es, ec, ev});
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] ms;
      logic         mco;
      logic         mov;
      logic [31:0]  bad;

      vecs[0] = '{8'h5A, 8'h33, 1'b0, 8'h8D, 1'b0, 1'b1};
      vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
      vecs[2] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0, 1'b1};
      vecs[3] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
      vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
      vecs[5] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
      vecs[6] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};

      rst = 1'b1;
      start = 1'b0;
      a = '0;
      b = '0;
      cin = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_state", {20'd0, busy, done, sum, cout, ovf}, 32'd0);
      rst = 1'b0;

      foreach (vecs[i]) begin
         a = vecs[i].a;
         b = vecs[i].b;
         cin = vecs[i].cin;
         start = 1'b1;
         run_op($sformatf("vec%0d", i), vecs[i].sum, vecs[i].cout,
                vecs[i].ovf, 1'b0);
         idle_check($sformatf("vec%0d", i), vecs[i].sum, vecs[i].cout,
                    vecs[i].ovf);
      end

      a = 8'h12;
      b = 8'h34;
      cin = 1'b0;
      start = 1'b1;
      run_op("noise", 8'h46, 1'b0, 1'b0, 1'b1);
      idle_check("noise", 8'h46, 1'b0, 1'b0);
      idle_check("noise2", 8'h46, 1'b0, 1'b0);

      a = 8'h01;
      b = 8'h01;
      cin = 1'b0;
      start = 1'b1;
      run_op("b2b_a", 8'h02, 1'b0, 1'b0, 1'b0);
      a = 8'h10;
      b = 8'h20;
      start = 1'b1;
      run_op("b2b_b", 8'h30, 1'b0, 1'b0, 1'b0);
      idle_check("b2b_b", 8'h30, 1'b0, 1'b0);

      a = 8'hAA;
      b = 8'h55;
      cin = 1'b0;
      start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid", {20'd0, busy, done, sum, cout, ovf}, 32'd0);
      bad = '0;
      for (int k = 0; k < W + 2; k++) begin
         @(negedge clk);
         if (busy || done) bad[k] = 1'b1;
      end
      check("rst_mid_quiet", bad, 32'd0);
      a = 8'h03;
      b = 8'h04;
      start = 1'b1;
      run_op("rst_after", 8'h07, 1'b0, 1'b0, 1'b0);
      idle_check("rst_after", 8'h07, 1'b0, 1'b0);

      a = 8'h5A;
      b = 8'h33;
      start = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      start = 1'b0;
      bad = '0;
      for (int k = 0; k < W + 2; k++) begin
         if (busy || done || sum != 0 || cout || ovf) bad[k] = 1'b1;
         @(negedge clk);
      end
      check("collision", bad, 32'd0);

      for (int i = 0; i < 40; i++) begin
         a = W'($urandom);
         b = W'($urandom);
         cin = 1'($urandom);
         model(a, b, cin, ms, mco, mov);
         start = 1'b1;
         run_op($sformatf("rnd%0d", i), ms, mco, mov, 1'($urandom));
         if ($urandom_range(0, 1) == 0)
            idle_check($sformatf("rnd%0d", i), ms, mco, mov);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_adder_ctrl.md
# serial_adder_ctrl

Bit-serial adder controller for the calculator datapath. It time-shares a single 1-bit full-adder cell, built from two half-adder instances, across the bits of a WIDTH-bit operand pair: LSB first, one bit per clock. A start/busy/done handshake brackets each operation. It sits between the calculator's operand registers and result register, and trades latency for a one-bit adder footprint.

## Interface
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- clk_i  input  1  system clock; all state changes on rising edge
- rst_i  input  1  synchronous, active-high reset
- start_i  input  1  request an addition; sampled only when busy_o=0
- a_i  input  WIDTH  operand A, two's complement or unsigned
- b_i  input  WIDTH  operand B
- cin_i  input  1  carry-in for bit 0
- busy_o  output  1  high while the operation is in progress (RUN state)
- done_o  output  1  one-cycle pulse: result valid
- sum_o  output  WIDTH  sum; holds until the next accepted start or reset
- cout_o  output  1  carry out of the MSB (unsigned overflow)
- ovf_o  output  1  signed overflow: carry into MSB XOR carry out of MSB

## Operation
- FSM states and transitions:
  - S_IDLE: start_i=1 → S_RUN.
  - S_RUN: bit counter = WIDTH-1 → S_DONE; otherwise stay in S_RUN.
  - S_DONE: start_i=1 → S_RUN; otherwise → S_IDLE.
- Start is accepted in S_IDLE or S_DONE (busy_o=0 in both).
- On accept:
  - a_i, b_i and cin_i are captured into internal shift registers and the carry flop.
  - The bit counter is cleared.
  - sum_o, cout_o and ovf_o are cleared.
  - Operand inputs are don't-care after the accept edge.
- Each S_RUN cycle:
  - The full adder takes the LSB of A, the LSB of B and the carry flop.
  - The sum bit shifts into the MSB end of the result shift register.
  - A and B shift right by one.
  - The carry flop takes the new carry.
  - The counter increments.
- MSB cycle (counter = WIDTH-1):
  - The carry flop's value before the add (carry into MSB) is latched for the ovf computation.
  - cout_o ← new carry.
  - ovf_o ← carry_in_msb XOR new carry.
- start_i in S_RUN is ignored; there is no queueing.
- Arithmetic is modulo 2^WIDTH; cout_o and ovf_o are both always computed, and the consumer selects the one it needs.
- Reset, including mid-operation: state → S_IDLE; counter, shift registers and carry flop → 0.

## Timing
- Reset values: busy_o=0, done_o=0, sum_o=0, cout_o=0, ovf_o=0.
- Latency:
  - Cycle 0 is the cycle in which start_i is sampled high.
  - busy_o is high in cycles 1..WIDTH.
  - done_o is high in cycle WIDTH+1 only.
  - sum_o, cout_o and ovf_o are valid from cycle WIDTH+1 and stable until the next accepted start.
- Throughput: with start_i held high during the done_o cycle, a new operation is accepted back to back, giving one result every WIDTH+1 cycles.
  - In that case sum_o is cleared one cycle after done_o.
  - The consumer must capture the result on done_o.
- rst_i and start_i high in the same cycle: reset wins, the start is dropped, and the FSM stays in S_IDLE.
- sum_o is the result shift register directly.
  - Partial values are visible during S_RUN.
  - Consumers must qualify sum_o with done_o or !busy_o.

## Structure
- Shared package calc_pkg:
  - typedef enum logic [1:0] serial_state_t {S_IDLE, S_RUN, S_DONE}.
  - Counter width derived as $clog2(WIDTH).
- Sub-module full_adder (a_i, b_i, c_i → s_o, c_o):
  - Built from two half_adder instances plus an OR on the two carries.
  - Instantiated once.
- All sequential logic lives in one always_ff process. Next-state logic and the full-adder hookup are combinational.

## Test plan (WIDTH=8)
- Signed overflow: 0x5A + 0x33, cin=0 → done_o in cycle 9; sum_o=0x8D, cout_o=0, ovf_o=1. busy_o high for exactly cycles 1..8.
- Unsigned carry: 0xFF + 0x01, cin=0 → sum_o=0x00, cout_o=1, ovf_o=0. Also 0x7F + 0x00, cin=1 → sum_o=0x80, cout_o=0, ovf_o=1.
- Operand change and ignored start: change a_i/b_i and pulse start_i during cycles 2..6 of 0x12 + 0x34 → sum_o=0x46, single done_o pulse, no restart.
- Back-to-back: start held high through the done_o cycle of 0x01 + 0x01, then 0x10 + 0x20 → done_o in cycles 9 and 18 with sum_o=0x02, then 0x30.
- Reset mid-operation: assert rst_i in cycle 4 of 0xAA + 0x55 → next cycle busy_o=0, sum_o=0, no done_o. A new start of 0x03 + 0x04 then yields 0x07.
- Reset/start collision: rst_i and start_i high together → no busy_o afterwards; all outputs remain 0.
